// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit, one bit per cycle
//
// Purpose: multi-cycle MUL/MUH/DIV/MOD (signed and unsigned) behind a
// valid/ready handshake. Multiply is shift-add, divide is restoring radix-2;
// both run on magnitudes and fix the sign when the result is registered.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle array multiply for
// ops 0-3; divides unchanged).
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_flush            synchronous abort, returns to IDLE
//   i_in_valid/o_in_ready   operation request handshake (ready only in IDLE)
//   i_op[2:0]          0 MUL 1 MULU 2 MUH 3 MUHU 4 DIV 5 DIVU 6 MOD 7 MODU
//   i_a, i_b           dividend/multiplicand, divisor/multiplier
//   o_out_valid/i_out_ready result handshake
//   o_result           selected result word, held through DONE
//   o_div_zero         divide/mod by zero flag, qualified by o_out_valid
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_div_zero;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;   // op[2]: divide family
  logic               r_sel_hi;   // op[1]: high product word / remainder
  logic               r_neg;      // negate the final result
  logic               r_dz;       // divide by zero, skip iteration
  // Shared datapath: r_hi is the upper accumulator / partial remainder,
  // r_lo the multiplier / dividend-becoming-quotient, r_b the fixed operand.
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_hi_nx;
  logic [WIDTH-1:0]   w_lo_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_div_res;
  logic [WIDTH-1:0]   w_final;
  logic               w_fast_mul;
  logic               w_last;

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_div_zero  = r_div_zero;

  assign w_signed = ~i_op[0];
  assign w_a_mag  = (w_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag  = (w_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

  // Multiply step: add r_b when the current multiplier bit is set, then
  // shift the whole {hi,lo} accumulator right by one.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Restoring divide step: partial remainder is always below the divisor,
  // so the shifted value fits WIDTH+1 bits and bit WIDTH of the difference
  // is a clean borrow flag.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_q_bit = ~w_diff[WIDTH];

  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_is_div) begin
      w_hi_nx = w_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_q_bit};
    end else begin
      w_hi_nx = w_sum[WIDTH:1];
      w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

`ifdef MDU_FAST_MUL_EN
  assign w_fast_mul = ~r_is_div;
  assign w_prod     = {{WIDTH{1'b0}}, r_lo} * {{WIDTH{1'b0}}, r_b};
`else
  assign w_fast_mul = 1'b0;
  assign w_prod     = {w_hi_nx, w_lo_nx};
`endif

  assign w_prod_s  = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
  assign w_div_res = r_sel_hi ? w_hi_nx : w_lo_nx;

  // Result word as it will look after this edge's iteration.
  always_comb begin
    w_final = '0;
    if (r_dz)
      w_final = r_sel_hi ? r_lo : '1;
    else if (r_is_div)
      w_final = r_neg ? (~w_div_res + WIDTH'(1)) : w_div_res;
    else
      w_final = r_sel_hi ? w_prod_s[2*WIDTH-1:WIDTH] : w_prod_s[WIDTH-1:0];
  end

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || r_dz || w_fast_mul;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_div_zero  <= 1'b0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_sel_hi    <= 1'b0;
      r_neg       <= 1'b0;
      r_dz        <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
    end else if (i_flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_is_div <= i_op[2];
            r_sel_hi <= i_op[1];
            r_dz     <= i_op[2] && (i_b == '0);
            // Remainder follows the dividend; product/quotient the xor.
            r_neg    <= w_signed && ((i_op[2] && i_op[1]) ? i_a[WIDTH-1]
                                                          : (i_a[WIDTH-1] ^ i_b[WIDTH-1]));
            r_hi     <= '0;
            // Divide by zero returns the raw dividend as remainder.
            r_lo     <= (i_op[2] && (i_b == '0)) ? i_a : w_a_mag;
            r_b      <= w_b_mag;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result    <= w_final;
            r_div_zero  <= r_dz;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter
module tb_mdu_iter;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W;
`endif

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         div_zero;

  int n_pass  = 0;
  int n_total = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op, measure latency, check result, then consume it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_res,
                        input logic exp_dz, input int exp_lat);
    int n;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " busy"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst div_zero", 64'(div_zero), 64'd0);
    rst_n = 1'b1;

    run_op("mulu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, MUL_LAT);
    run_op("muhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, MUL_LAT);
    run_op("mul_neg",  3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, MUL_LAT);
    run_op("muh_neg",  3'd2, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 1'b0, MUL_LAT);
    run_op("div_m7",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, W);
    run_op("mod_m7",   3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, W);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, W);
    run_op("mod_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, W);
    run_op("divu_z",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1);
    run_op("modu_z",   3'd7, 32'd5,        32'd0,        32'h00000005, 1'b1, 1);
    run_op("mod_z_neg", 3'd6, 32'hFFFFFFF9, 32'd0,       32'hFFFFFFF9, 1'b1, 1);

    // Backpressure: DIVU 100/7 held in DONE for 5 cycles.
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp latency", 64'(n), 64'(W));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp valid", 64'(out_valid), 64'd1);
      check("bp result", 64'(result), 64'h0000000E);
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp ready_after", 64'(in_ready), 64'd1);
    check("bp valid_after", 64'(out_valid), 64'd0);

    // Flush on cycle 10 of a DIV.
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush no_valid", 64'(seen), 64'd0);
    run_op("mulu_after_flush", 3'd1, 32'd3, 32'd4, 32'h0000000C, 1'b0, MUL_LAT);

    // Asynchronous reset mid-MUL (skipped latency effect under fast mul is fine:
    // reset still lands while the op is in BUSY or DONE).
    op = 3'd0; a = 32'd7; b = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst in_ready", 64'(in_ready), 64'd1);
    check("arst out_valid", 64'(out_valid), 64'd0);
    check("arst result", 64'(result), 64'd0);
    check("arst div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mulu_after_rst", 3'd1, 32'd3, 32'd4, 32'h0000000C, 1'b0, MUL_LAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised, multi-cycle multiply/divide unit that replaces the single-cycle `*`, `/` and `%` paths of the execute-stage ALU. It accepts one operation at a time over a valid/ready handshake and iterates one bit per cycle. It returns the low or high product word, the quotient or the remainder, with signed and unsigned variants. The pipeline's hazard logic stalls on `in_ready`/`out_valid`, so the ALU's critical path no longer contains a full-width multiplier or divider.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived, do not override).

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset; one clock domain.
- `flush` in 1: synchronous abort of any operation in flight.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `op` in 3: operation select.
  - 0 MUL, 1 MULU: low product word.
  - 2 MUH, 3 MUHU: high product word.
  - 4 DIV, 5 DIVU: quotient.
  - 6 MOD, 7 MODU: remainder.
- `a` in WIDTH: dividend / multiplicand.
- `b` in WIDTH: divisor / multiplier.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `result` out WIDTH: selected result word.
- `div_zero` out 1: qualified by `out_valid`; set when a divide/mod had `b == 0`.

## Operation
- **States:**
  - IDLE → BUSY on `in_valid && in_ready`.
  - BUSY → DONE when the iteration counter reaches WIDTH.
  - DONE → IDLE on `out_ready`.
- **Accept edge:**
  - latch `op`.
  - latch operand magnitudes for signed ops (MUL, MUH, DIV, MOD); raw operands for unsigned ops.
  - latch result sign: `a[W-1]^b[W-1]` for product and quotient; `a[W-1]` for remainder.
  - clear counter.
- **Multiply:** shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle. The final value is negated if the result sign is set.
  - MUL/MULU return `[W-1:0]`.
  - MUH/MUHU return `[2W-1:W]`.
- **Divide:** restoring radix-2, one quotient bit per cycle over a WIDTH+1 partial remainder.
  - The quotient is negated if its sign is set.
  - The remainder takes the dividend's sign, so results truncate toward zero.
- **Divide by zero (ops 4–7, `b == 0`):**
  - no iteration; go straight to DONE.
  - `div_zero` = 1.
  - quotient = all-ones; remainder = `a` unmodified.
- **Signed overflow** (`a` = MIN, `b` = −1): quotient = MIN, remainder = 0. The magnitude datapath yields this without a special case.
- **Result holding:** `result` and `div_zero` are registered and held stable for the whole of DONE. Outside DONE they are don't-care but must not toggle spuriously; hold the last value.
- **`flush`:** in any state, go to IDLE on the next edge and drop `out_valid`. `flush` has priority over `in_valid` in the same cycle.

## Timing
- **Reset values:**
  - state IDLE, so `in_ready` = 1.
  - `out_valid` = 0.
  - `result` = 0.
  - `div_zero` = 0.
  - counter = 0.
- **Latency:** accept on edge E0.
  - Iterations occur on E1..E_WIDTH.
  - `out_valid` is high in the cycle following E_WIDTH, i.e. WIDTH cycles after acceptance.
  - Divide-by-zero: `out_valid` after E1.
- **Throughput:**
  - `in_ready` is low from the cycle after acceptance until the cycle after the DONE handshake.
  - Minimum interval between accepts is WIDTH+2 cycles.
  - `in_ready` is combinational from state only, never from `in_valid`.
- **Backpressure:** `out_ready` low holds DONE indefinitely, with `result` unchanged.
- **Asynchronous `rst_n` mid-operation:** immediately returns every output to its reset value. No partial result is ever presented.

## Configuration
- **`MDU_FAST_MUL_EN` defined:**
  - ops 0–3 compute the full signed/unsigned product with a single-cycle array multiplier.
  - BUSY is skipped and `out_valid` is asserted after E1.
  - divides are unchanged.
- **`MDU_FAST_MUL_EN` undefined:** multiplies use the shift-add path with WIDTH-cycle latency. No multiplier primitive is inferred.

## Test plan
- MULU then MUHU, `a` = `b` = 0xFFFFFFFF (WIDTH=32):
  - `result` 0x00000001 then 0xFFFFFFFE.
  - `out_valid` after 32 cycles, or 1 cycle with `MDU_FAST_MUL_EN`.
- DIV and MOD, `a` = 0xFFFFFFF9 (−7), `b` = 2: `result` 0xFFFFFFFD (−3) and 0xFFFFFFFF (−1); `div_zero` = 0.
- DIV and MOD, `a` = 0x80000000, `b` = 0xFFFFFFFF: `result` 0x80000000 and 0x00000000.
- DIVU and MODU, `a` = 5, `b` = 0:
  - `div_zero` = 1, `out_valid` one cycle after accept.
  - `result` 0xFFFFFFFF and 0x00000005.
- DIVU 100/7 with `out_ready` held low 5 cycles in DONE:
  - `result` stays 0x0000000E and `in_ready` stays 0.
  - `in_ready` returns 1 the cycle after the `out_ready` pulse.
- Abort cases:
  - `flush` on cycle 10 of a DIV: IDLE next cycle and `out_valid` never asserts.
  - `rst_n` pulsed low mid-MUL: all outputs at reset values immediately.
  - a new MULU 3×4 after either abort returns 0x0000000C.
